pe_feeder: RTL and testbench

PE_FEEDER -- requirements
Module: pe_feeder

---
 rtl/pe_feeder.sv | 150 +++++++++++++++
 tb/tb_pe_feeder.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pe_feeder.sv
// Feeds a processing element: loads one kernel of weights, then streams activation windows tagged with window/pool boundaries.
// Optional macro PE_FEEDER_STALL_CNT_EN adds a saturating count of STREAM cycles without an accepted activation beat.
module pe_feeder #(
    parameter int DATA_WID   = 8,
    parameter int ICP_NUM    = 4,
    parameter int ADDR_B     = 4,
    parameter int KERNEL_LEN = 9,
    parameter int POOL_WIN   = 4
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        start,
    input  logic [7:0]                  num_windows,
    input  logic                        wt_valid,
    input  logic [DATA_WID-1:0]         wt_data,
    output logic                        wt_ready,
    input  logic                        act_valid,
    input  logic [ICP_NUM*DATA_WID-1:0] act_data,
    output logic                        act_ready,
    output logic [1:0]                  pk_state,
    output logic [ICP_NUM*DATA_WID-1:0] pk_A,
    output logic [DATA_WID-1:0]         pk_wrb_data,
    output logic [ADDR_B-1:0]           pk_wrb_addr,
    output logic [ICP_NUM-1:0]          pk_wrb,
    output logic [ADDR_B-1:0]           pk_rdb_addr,
    output logic                        busy,
    output logic                        done,
    output logic [15:0]                 stall_cnt
);
    typedef enum logic [1:0] {S_IDLE, S_LOAD_WT, S_STREAM, S_DONE} state_t;

    localparam logic [1:0] PE_INVALID  = 2'd0;
    localparam logic [1:0] PE_VALID    = 2'd1;
    localparam logic [1:0] PE_CNN_FIN  = 2'd2;
    localparam logic [1:0] PE_POOL_FIN = 2'd3;

    localparam logic [ADDR_B-1:0] LAST_K = ADDR_B'(KERNEL_LEN - 1);
    localparam logic [7:0]        LAST_P = 8'(POOL_WIN - 1);

    state_t            state;
    logic [7:0]        nw_q;
    logic [7:0]        win_cnt;
    logic [7:0]        pool_cnt;
    logic [ADDR_B-1:0] wt_idx;
    logic [ADDR_B-1:0] beat_idx;
    logic              wt_acc;
    logic              act_acc;
    logic              last_beat;
    logic              last_win;
    logic              group_end;

    // Handshake: a beat transfers on a rising edge where valid and ready are both high.
    assign wt_ready  = (state == S_LOAD_WT);
    assign act_ready = (state == S_STREAM);
    assign busy      = (state != S_IDLE);
    assign wt_acc    = wt_valid & wt_ready;
    assign act_acc   = act_valid & act_ready;
    assign last_beat = (beat_idx == LAST_K);
    assign last_win  = ((win_cnt + 8'd1) == nw_q);
    assign group_end = (pool_cnt == LAST_P);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= S_IDLE;
            nw_q        <= '0;
            win_cnt     <= '0;
            pool_cnt    <= '0;
            wt_idx      <= '0;
            beat_idx    <= '0;
            pk_state    <= PE_INVALID;
            pk_A        <= '0;
            pk_wrb_data <= '0;
            pk_wrb_addr <= '0;
            pk_wrb      <= '0;
            pk_rdb_addr <= '0;
            done        <= 1'b0;
        end else begin
            // Bubble defaults; write/read addresses and weight data hold.
            pk_state <= PE_INVALID;
            pk_A     <= '0;
            pk_wrb   <= '0;
            done     <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        nw_q     <= num_windows;
                        win_cnt  <= '0;
                        pool_cnt <= '0;
                        wt_idx   <= '0;
                        beat_idx <= '0;
                        state    <= S_LOAD_WT;
                    end
                end
                S_LOAD_WT: begin
                    if (wt_acc) begin
                        pk_wrb_data <= wt_data;
                        pk_wrb_addr <= wt_idx;
                        pk_wrb      <= '1;
                        if (wt_idx == LAST_K) begin
                            wt_idx <= '0;
                            state  <= (nw_q != 8'd0) ? S_STREAM : S_DONE;
                        end else begin
                            wt_idx <= wt_idx + 1'b1;
                        end
                    end
                end
                S_STREAM: begin
                    if (act_acc) begin
                        pk_A        <= act_data;
                        pk_rdb_addr <= beat_idx;
                        if (last_beat) begin
                            beat_idx <= '0;
                            win_cnt  <= win_cnt + 8'd1;
                            pool_cnt <= group_end ? 8'd0 : pool_cnt + 8'd1;
                            pk_state <= (group_end || last_win) ? PE_POOL_FIN : PE_CNN_FIN;
                            if (last_win) state <= S_DONE;
                        end else begin
                            beat_idx <= beat_idx + 1'b1;
                            pk_state <= PE_VALID;
                        end
                    end
                end
                S_DONE: begin
                    done  <= 1'b1;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef PE_FEEDER_STALL_CNT_EN
    logic [15:0] stall_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_q <= '0;
        end else if (state == S_IDLE && start) begin
            stall_q <= '0;
        end else if (state == S_STREAM && !act_acc && stall_q != 16'hFFFF) begin
            stall_q <= stall_q + 16'd1;
        end
    end

    assign stall_cnt = stall_q;
`else
    assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_pe_feeder.sv
// Self-checking bench for pe_feeder: randomized jobs compared cycle by cycle against a job-level reference model.
module tb_pe_feeder;
    localparam int DW  = 8;
    localparam int ICP = 4;
    localparam int AB  = 4;
    localparam int KL  = 9;
    localparam int PW  = 4;

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic [7:0]        num_windows;
    logic              wt_valid;
    logic [DW-1:0]     wt_data;
    logic              wt_ready;
    logic              act_valid;
    logic [ICP*DW-1:0] act_data;
    logic              act_ready;
    logic [1:0]        pk_state;
    logic [ICP*DW-1:0] pk_A;
    logic [DW-1:0]     pk_wrb_data;
    logic [AB-1:0]     pk_wrb_addr;
    logic [ICP-1:0]    pk_wrb;
    logic [AB-1:0]     pk_rdb_addr;
    logic              busy;
    logic              done;
    logic [15:0]       stall_cnt;

    // clock / reset
    always #5 clk = ~clk;

    pe_feeder #(.DATA_WID(DW), .ICP_NUM(ICP), .ADDR_B(AB), .KERNEL_LEN(KL), .POOL_WIN(PW)) dut (
        .clk(clk), .reset(reset), .start(start), .num_windows(num_windows),
        .wt_valid(wt_valid), .wt_data(wt_data), .wt_ready(wt_ready),
        .act_valid(act_valid), .act_data(act_data), .act_ready(act_ready),
        .pk_state(pk_state), .pk_A(pk_A), .pk_wrb_data(pk_wrb_data), .pk_wrb_addr(pk_wrb_addr),
        .pk_wrb(pk_wrb), .pk_rdb_addr(pk_rdb_addr), .busy(busy), .done(done), .stall_cnt(stall_cnt)
    );

    int vectors     = 0;
    int miscompares = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // reference model: job phase (0 idle, 1 weights, 2 stream, 3 finishing) and expected outputs
    int              m_phase, m_wt_k, m_beats, m_nw;
    logic [DW-1:0]   e_wrb_data;
    logic [AB-1:0]   e_wrb_addr, e_rdb;
    logic [ICP-1:0]  e_wrb;
    logic [1:0]      e_state;
    logic [ICP*DW-1:0] e_A;
    logic            e_done;
    logic [15:0]     e_stall;

    // driver knobs
    int   wt_pct = 100, act_pct = 100, gap_at = -1, gap_left = 0;
    logic pattern_mode = 1'b0;
    logic record_ends  = 1'b0;
    logic [1:0] ends_obs[$];
    logic [1:0] exp_q[$];

    task automatic model_reset();
        m_phase = 0; m_wt_k = 0; m_beats = 0; m_nw = 0;
        e_wrb_data = '0; e_wrb_addr = '0; e_rdb = '0; e_wrb = '0;
        e_state = 2'd0; e_A = '0; e_done = 1'b0; e_stall = '0;
    endtask

    task automatic model_edge();
        int idx, win;
        e_wrb = '0; e_state = 2'd0; e_A = '0; e_done = 1'b0;
        case (m_phase)
            0: if (start) begin
                m_nw = int'(num_windows); m_wt_k = 0; m_beats = 0; m_phase = 1;
`ifdef PE_FEEDER_STALL_CNT_EN
                e_stall = '0;
`endif
            end
            1: if (wt_valid) begin
                e_wrb = '1; e_wrb_data = wt_data; e_wrb_addr = AB'(m_wt_k);
                m_wt_k++;
                if (m_wt_k == KL) m_phase = (m_nw > 0) ? 2 : 3;
            end
            2: if (act_valid) begin
                idx = m_beats % KL;
                win = m_beats / KL;
                e_A = act_data;
                e_rdb = AB'(idx);
                if (idx < KL - 1) e_state = 2'd1;
                else if ((win % PW) == PW - 1 || win == m_nw - 1) e_state = 2'd3;
                else e_state = 2'd2;
                m_beats++;
                if (m_beats == m_nw * KL) m_phase = 3;
            end else begin
`ifdef PE_FEEDER_STALL_CNT_EN
                if (e_stall != 16'hFFFF) e_stall = e_stall + 16'd1;
`endif
            end
            default: begin
                e_done = 1'b1; m_phase = 0;
            end
        endcase
    endtask

    task automatic compare_all();
        check("pk_state", pk_state, e_state);
        check("pk_A", pk_A, e_A);
        check("pk_wrb", pk_wrb, e_wrb);
        check("pk_wrb_addr", pk_wrb_addr, e_wrb_addr);
        check("pk_wrb_data", pk_wrb_data, e_wrb_data);
        check("pk_rdb_addr", pk_rdb_addr, e_rdb);
        check("wt_ready", wt_ready, m_phase == 1);
        check("act_ready", act_ready, m_phase == 2);
        check("busy", busy, m_phase != 0);
        check("done", done, e_done);
        check("stall_cnt", stall_cnt, e_stall);
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        compare_all();
        if (record_ends && (e_state == 2'd2 || e_state == 2'd3)) ends_obs.push_back(pk_state);
    endtask

    // driver: randomized beats, occasional start while busy (must be ignored)
    task automatic drive();
        start = 1'b0;
        if (m_phase != 0 && $urandom_range(0, 15) == 0) begin
            start = 1'b1;
            num_windows = 8'($urandom);
        end
        wt_valid = ($urandom_range(0, 99) < wt_pct);
        wt_data  = pattern_mode ? DW'(m_wt_k + 1) : DW'($urandom);
        act_valid = ($urandom_range(0, 99) < act_pct);
        if (gap_left > 0 && m_phase == 2 && m_beats == gap_at) begin
            act_valid = 1'b0;
            gap_left--;
        end
        if (pattern_mode) begin
            for (int j = 0; j < ICP; j++) act_data[j*DW +: DW] = DW'(j * 16 + (m_beats % KL));
        end else begin
            act_data = $urandom;
        end
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            start = 1'b0; wt_valid = $urandom; act_valid = $urandom;
            step();
        end
    endtask

    task automatic run_job(input int nw);
        int n;
        start = 1'b1; num_windows = 8'(nw); wt_valid = 1'b0; act_valid = 1'b0;
        step();
        n = 0;
        while (m_phase != 0 && n < 4000) begin
            drive();
            step();
            n++;
        end
        check("job_within_budget", n < 4000, 1'b1);
        idle_cycles(2);
    endtask

    initial begin
        reset = 1'b0; start = 1'b0; num_windows = '0; wt_valid = 1'b0; wt_data = '0;
        act_valid = 1'b0; act_data = '0;
        model_reset();
        #3;
        compare_all();
        @(negedge clk) reset = 1'b1;
        idle_cycles(3);

        // weights 1..9 back to back, one window with lane pattern
        pattern_mode = 1'b1;
        run_job(1);
        pattern_mode = 1'b0;

        // five windows: pool boundaries at window 4 and at job end
        record_ends = 1'b1;
        run_job(5);
        record_ends = 1'b0;
        exp_q = '{2'd2, 2'd2, 2'd2, 2'd3, 2'd3};
        check("window_end_count", ends_obs.size(), exp_q.size());
        while (exp_q.size() > 0 && ends_obs.size() > 0)
            check("window_end_state", ends_obs.pop_front(), exp_q.pop_front());

        // three-cycle activation gap mid-window
        gap_at = 4; gap_left = 3;
        run_job(1);
`ifdef PE_FEEDER_STALL_CNT_EN
        check("stall_at_done", stall_cnt, 16'd3);
`else
        check("stall_at_done", stall_cnt, 16'd0);
`endif
        gap_at = -1;

        // empty job: weights only
        run_job(0);

        // reset asserted during streaming beat 4, then a fresh job
        begin
            int n;
            start = 1'b1; num_windows = 8'd3; step();
            n = 0;
            while (!(m_phase == 2 && m_beats == 4) && n < 200) begin
                drive(); step(); n++;
            end
            check("reach_stream_beat4", n < 200, 1'b1);
            reset = 1'b0;
            #1;
            model_reset();
            compare_all();
            @(posedge clk); #1;
            compare_all();
            @(negedge clk) reset = 1'b1;
            idle_cycles(1);
            run_job(2);
        end

        // randomized jobs with random back-pressure
        for (int j = 0; j < 20; j++) begin
            wt_pct  = $urandom_range(50, 100);
            act_pct = $urandom_range(40, 100);
            run_job($urandom_range(0, 9));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
